// File: rtl/audio_i2s_rx_if.sv
// Stereo sample bus from the I2S receiver to the audio mixer.
// The receiver drives the master side; the mixer reads the slave side.
interface audio_i2s_rx_if #(
   parameter int DW = 16
);
   logic signed [DW-1:0] ldata;
   logic signed [DW-1:0] rdata;
   logic                 valid;

   modport master (output ldata, output rdata, output valid);
   modport slave  (input  ldata, input  rdata, input  valid);
endinterface

// File: rtl/audio_i2s_rx.sv
// I2S receiver (ADC path). Oversamples BCLK/LRCK/SDATA in the clk domain,
// deserialises MSB-first left/right words and presents each completed pair
// on the sample bus with a one-cycle valid strobe.
//
// Frame timing: the rising BCLK edge on which a new LRCK level is first seen
// (a boundary) still carries the last bit of the previous slot, so it doubles
// as the one-bit I2S delay slot of the new channel; the MSB arrives on the
// following rise. A word whose DW-th bit lands exactly on the boundary (slot
// length == DW) is therefore completed on that boundary rise.
module audio_i2s_rx #(
   parameter int DW   = 16,
   parameter int CNTW = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           exchan,
   input  logic           err_clr,
   input  logic           aud_bclk,
   input  logic           aud_adclrck,
   input  logic           aud_adcdat,
   audio_i2s_rx_if.master smp,
   output logic           frame_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAD   = 2'd2
   } state_t;

   localparam logic [CNTW-1:0] LAST_BIT = CNTW'(DW - 1);

   // Bit counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic bclk_s1, bclk_s2, bclk_s3;
   logic lrck_s1, lrck_s2;
   logic dat_s1, dat_s2;

   logic rise, lr, d, boundary, last_bit;

   state_t state, state_nxt;
   logic [CNTW-1:0]      cnt;
   logic [DW-2:0]        shreg;
   logic signed [DW-1:0] word;
   logic signed [DW-1:0] lhold;
   logic                 lr_prev;
   logic                 lgood;

   logic shift, take, cnt_clr, set_err, lgood_clr, commit;

   // Two-flop synchronisers for the I2S pins plus a third BCLK flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_s3 <= 1'b0;
         lrck_s1 <= 1'b0;
         lrck_s2 <= 1'b0;
         dat_s1  <= 1'b0;
         dat_s2  <= 1'b0;
      end else begin
         bclk_s1 <= aud_bclk;
         bclk_s2 <= bclk_s1;
         bclk_s3 <= bclk_s2;
         lrck_s1 <= aud_adclrck;
         lrck_s2 <= lrck_s1;
         dat_s1  <= aud_adcdat;
         dat_s2  <= dat_s1;
      end
   end

   assign rise     = bclk_s2 & ~bclk_s3;
   assign lr       = lrck_s2;
   assign d        = dat_s2;
   assign boundary = lr ^ lr_prev;
   assign last_bit = (cnt == LAST_BIT);
   assign word     = {shreg, d};
   // lr_prev is the channel of the slot being shifted; a right word completes the pair.
   assign commit   = take & lr_prev & lgood;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and datapath control; everything except leaving on en=0 waits for a BCLK rise.
   always_comb begin
      state_nxt = state;
      shift     = 1'b0;
      take      = 1'b0;
      cnt_clr   = 1'b0;
      set_err   = 1'b0;
      lgood_clr = (state == IDLE);
      if (!en) begin
         state_nxt = IDLE;
         lgood_clr = 1'b1;
      end else if (rise) begin
         case (state)
            IDLE: begin
               // Only the start of a left slot locks the receiver.
               if (boundary && !lr) begin
                  state_nxt = SHIFT;
                  cnt_clr   = 1'b1;
               end
            end
            SHIFT: begin
               shift = !boundary || last_bit;
               take  = last_bit;
               if (boundary) begin
                  cnt_clr = 1'b1;
                  set_err = !last_bit;
                  if (lr && !last_bit) begin
                     // Left word lost: its right partner must not be paired, re-lock on next left.
                     state_nxt = IDLE;
                     lgood_clr = 1'b1;
                  end else begin
                     state_nxt = SHIFT;
                     lgood_clr = !lr;
                  end
               end else if (last_bit) begin
                  state_nxt = PAD;
               end
            end
            PAD: begin
               if (boundary) begin
                  state_nxt = SHIFT;
                  cnt_clr   = 1'b1;
                  lgood_clr = !lr;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Shift register, bit counter, word holding, pair commit and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_prev   <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         lhold     <= '0;
         lgood     <= 1'b0;
         smp.ldata <= '0;
         smp.rdata <= '0;
         smp.valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         smp.valid <= 1'b0;
         if (rise) lr_prev <= lr;

         if (cnt_clr)    cnt <= '0;
         else if (shift) cnt <= sat_inc(cnt);

         if (shift) shreg <= word[DW-2:0];

         if (take && !lr_prev) lhold <= word;

         if (lgood_clr)             lgood <= 1'b0;
         else if (take && !lr_prev) lgood <= 1'b1;

         if (commit) begin
            smp.valid <= 1'b1;
            if (exchan) begin
               smp.ldata <= word;
               smp.rdata <= lhold;
            end else begin
               smp.ldata <= lhold;
               smp.rdata <= word;
            end
         end

         if (set_err)      frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
      end
   end

endmodule
